// File: rtl/proto_sched_pkg.sv
// Shared types and constants for the round-robin protocol transaction scheduler.
package proto_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_e;

    localparam int DEF_DW      = 4;
    localparam int DEF_TIMEOUT = 15;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/proto_txn_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first valid request after last_grant, with wrap-around.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_idx
);

    // Walk candidates last_grant+1 .. last_grant+NUM_REQ (mod NUM_REQ); first hit wins.
    always_comb begin
        logic [IW:0] cand;
        logic        found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = {1'b0, last_grant} + (IW+1)'(i);
            if (cand >= (IW+1)'(NUM_REQ)) begin
                cand = cand - (IW+1)'(NUM_REQ);
            end else begin
                cand = cand;
            end
            if (!found && req[cand[IW-1:0]]) begin
                grant[cand[IW-1:0]] = 1'b1;
                grant_idx           = cand[IW-1:0];
                found               = 1'b1;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/proto_txn_scheduler.sv
// Shares one protocol core between NUM_REQ requesters: accept, issue start, wait for
// completion or timeout, then return a one-cycle response to the granted requester.
module proto_txn_scheduler
    import proto_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_rw,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [DW-1:0]         rsp_rdata,
    output logic                  rsp_err,
    output logic                  start,
    output logic                  rw_out,
    output logic [DW-1:0]         wdata_out,
    input  logic                  core_done,
    input  logic [DW-1:0]         core_rdata,
    output logic                  busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    sched_state_e        state_r;
    sched_state_e        state_next_s;
    logic [NUM_REQ-1:0]  arb_grant_s;
    logic [IW-1:0]       arb_idx_s;
    logic [IW-1:0]       grant_idx_r;
    logic [IW-1:0]       last_grant_r;
    logic [TW-1:0]       timer_r;
    logic                accept_s;
    logic                timeout_s;
    logic [NUM_REQ-1:0]  rsp_valid_r;
    logic [DW-1:0]       rsp_rdata_r;
    logic                rsp_err_r;
    logic                start_r;
    logic                rw_out_r;
    logic [DW-1:0]       wdata_out_r;
    logic                busy_r;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant_r),
        .grant      (arb_grant_s),
        .grant_idx  (arb_idx_s)
    );

    assign accept_s  = (state_r == IDLE) && (|arb_grant_s);
    assign timeout_s = (timer_r == TW'(TIMEOUT - 1));

    // Accept strobe is only offered while idle.
    always_comb begin
        req_ready = '0;
        if (state_r == IDLE) begin
            req_ready = arb_grant_s;
        end else begin
            req_ready = '0;
        end
    end

    // Next-state logic; completion takes precedence over timeout.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = ISSUE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE: state_next_s = WAIT;
            WAIT: begin
                if (core_done || timeout_s) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = WAIT;
                end
            end
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath and registered outputs; start and rsp_valid are single-cycle pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_idx_r  <= '0;
            last_grant_r <= IW'(NUM_REQ - 1);
            timer_r      <= '0;
            rsp_valid_r  <= '0;
            rsp_rdata_r  <= '0;
            rsp_err_r    <= 1'b0;
            start_r      <= 1'b0;
            rw_out_r     <= RW_WRITE;
            wdata_out_r  <= '0;
            busy_r       <= 1'b0;
        end else begin
            start_r     <= 1'b0;
            rsp_valid_r <= '0;
            busy_r      <= (state_next_s != IDLE);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        grant_idx_r <= arb_idx_s;
                        rw_out_r    <= req_rw[arb_idx_s];
                        wdata_out_r <= req_wdata[int'(arb_idx_s)*DW +: DW];
                        start_r     <= 1'b1;
                    end else begin
                        grant_idx_r <= grant_idx_r;
                    end
                end
                ISSUE: begin
                    timer_r <= '0;
                end
                WAIT: begin
                    if (core_done) begin
                        rsp_rdata_r              <= core_rdata;
                        rsp_err_r                <= 1'b0;
                        rsp_valid_r[grant_idx_r] <= 1'b1;
                    end else if (timeout_s) begin
                        rsp_rdata_r              <= '0;
                        rsp_err_r                <= 1'b1;
                        rsp_valid_r[grant_idx_r] <= 1'b1;
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                RESP: begin
                    last_grant_r <= grant_idx_r;
                end
                default: begin
                    timer_r <= '0;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign start     = start_r;
    assign rw_out    = rw_out_r;
    assign wdata_out = wdata_out_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_proto_txn_scheduler.sv
// Scoreboard bench for proto_txn_scheduler: directed transactions, a modelled core,
// and a negedge monitor that checks grants, start pulses and responses against queues.
module tb_proto_txn_scheduler;
    import proto_sched_pkg::*;

    localparam int NR = 2;
    localparam int W  = 4;
    localparam int TO = 15;

    typedef struct {
        int         idx;
        logic [3:0] rdata;
        logic       err;
        int         lat;
    } rsp_t;

    typedef struct {
        logic       rw;
        logic [3:0] wd;
        int         delay;
        logic [3:0] crd;
    } core_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_rw;
    logic [NR*W-1:0] req_wdata;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   rsp_valid;
    logic [W-1:0]    rsp_rdata;
    logic            rsp_err;
    logic            start;
    logic            rw_out;
    logic [W-1:0]    wdata_out;
    logic            core_done;
    logic [W-1:0]    core_rdata;
    logic            busy;

    int    exp_grant[$];
    core_t exp_core[$];
    rsp_t  exp_rsp[$];

    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         accept_cyc = 0;
    int         accept_cnt = 0;
    int         core_cnt = 0;
    logic [3:0] pend_crd = 4'h0;
    int         stray_req = 0;
    int         stray_ack = 0;
    logic       start_prev = 1'b0;

    proto_txn_scheduler #(.NUM_REQ(NR), .DW(W), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_rw     (req_rw),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .start      (start),
        .rw_out     (rw_out),
        .wdata_out  (wdata_out),
        .core_done  (core_done),
        .core_rdata (core_rdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor and core model, both sampled on the falling edge.
    initial begin
        rsp_t  r;
        core_t c;
        int    g;
        forever begin
            @(negedge clk);
            if (req_ready !== '0) begin
                if (exp_grant.size() == 0) begin
                    chk("unexpected_grant", 32'(req_ready), 32'd0);
                end else begin
                    g = exp_grant.pop_front();
                    chk("grant", 32'(req_ready), 32'd1 << g);
                end
                accept_cyc = cyc;
                accept_cnt++;
            end
            if (rsp_valid !== '0) begin
                if (exp_rsp.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    r = exp_rsp.pop_front();
                    chk("rsp_valid", 32'(rsp_valid), 32'd1 << r.idx);
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(r.rdata));
                    chk("rsp_err", 32'(rsp_err), 32'(r.err));
                    chk("rsp_latency", 32'(cyc - accept_cyc), 32'(r.lat));
                    chk("busy_in_resp", 32'(busy), 32'd1);
                end
            end
            core_done = 1'b0;
            if (!rst) begin
                core_cnt = 0;
            end else if (core_cnt > 0) begin
                core_cnt--;
                if (core_cnt == 0) begin
                    core_done  = 1'b1;
                    core_rdata = pend_crd;
                end
            end
            if (start === 1'b1) begin
                chk("start_one_cycle", 32'(start_prev), 32'd0);
                if (exp_core.size() == 0) begin
                    chk("unexpected_start", 32'd1, 32'd0);
                end else begin
                    c = exp_core.pop_front();
                    chk("rw_out", 32'(rw_out), 32'(c.rw));
                    chk("wdata_out", 32'(wdata_out), 32'(c.wd));
                    core_cnt = c.delay;
                    pend_crd = c.crd;
                end
            end
            start_prev = start;
            if (stray_req != stray_ack) begin
                core_done  = 1'b1;
                core_rdata = 4'hF;
                stray_ack  = stray_req;
            end
        end
    end

    task automatic wait_accept(input int i);
        logic got = 1'b0;
        int   k = 0;
        while (!got && k < 50) begin
            @(negedge clk);
            got = req_ready[i];
            k++;
        end
        @(posedge clk);
        #1;
        chk("accept_seen", 32'(got), 32'd1);
    endtask

    task automatic wait_rsp();
        int k = 0;
        while (exp_rsp.size() != 0 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("rsp_seen", 32'(exp_rsp.size()), 32'd0);
        exp_rsp.delete();
    endtask

    task automatic do_txn(input int i, input logic rw, input logic [3:0] wd, input int delay,
                          input logic [3:0] crd, input logic [3:0] erd, input logic eerr,
                          input int lat);
        exp_grant.push_back(i);
        exp_core.push_back(core_t'{rw, wd, delay, crd});
        exp_rsp.push_back(rsp_t'{i, erd, eerr, lat});
        req_rw[i]          = rw;
        req_wdata[i*W +: W] = wd;
        req_valid[i]       = 1'b1;
        wait_accept(i);
        req_valid[i] = 1'b0;
        wait_rsp();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_start"}, 32'(start), 32'd0);
        chk({tag, "_rw_out"}, 32'(rw_out), 32'd0);
        chk({tag, "_wdata_out"}, 32'(wdata_out), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int base;
        int k;
        rst        = 1'b0;
        req_valid  = '0;
        req_rw     = '0;
        req_wdata  = '0;
        core_done  = 1'b0;
        core_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ready", 32'(req_ready), 32'd0);

        // Single write, done sampled at the earliest edge.
        do_txn(0, RW_WRITE, 4'hA, 1, 4'h3, 4'h3, 1'b0, 3);
        // Read return from requester 1.
        do_txn(1, RW_READ, 4'h0, 3, 4'h5, 4'h5, 1'b0, 5);

        // Fairness with both requesters held valid.
        for (int n = 0; n < 2; n++) begin
            exp_grant.push_back(0);
            exp_core.push_back(core_t'{RW_WRITE, 4'h1, 1, 4'h8});
            exp_rsp.push_back(rsp_t'{0, 4'h8, 1'b0, 3});
            exp_grant.push_back(1);
            exp_core.push_back(core_t'{RW_READ, 4'hE, 2, 4'h4});
            exp_rsp.push_back(rsp_t'{1, 4'h4, 1'b0, 4});
        end
        base      = accept_cnt;
        req_rw    = 2'b10;
        req_wdata = {4'hE, 4'h1};
        req_valid = 2'b11;
        k = 0;
        while (accept_cnt < base + 4 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        req_valid = '0;
        chk("fair_accepts", 32'(accept_cnt - base), 32'd4);
        wait_rsp();

        // Timeout: core never completes.
        do_txn(1, RW_READ, 4'h6, 0, 4'h0, 4'h0, 1'b1, TO + 2);
        chk("busy_after_timeout", 32'(busy), 32'd0);
        // Done on the last permitted WAIT cycle beats the timeout.
        do_txn(0, RW_WRITE, 4'h2, TO, 4'hC, 4'hC, 1'b0, TO + 2);

        // Stray core_done while idle.
        stray_req++;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("stray_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("stray_busy", 32'(busy), 32'd0);
        end

        // Reset in the middle of WAIT aborts silently.
        @(posedge clk);
        #1;
        exp_grant.push_back(0);
        exp_core.push_back(core_t'{RW_READ, 4'h7, 0, 4'h0});
        req_rw[0]       = RW_READ;
        req_wdata[3:0]  = 4'h7;
        req_valid[0]    = 1'b1;
        wait_accept(0);
        req_valid[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("busy_in_wait", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk_all_zero("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Priority restarts at requester 0, then requester 1 alone is served.
        req_rw    = 2'b00;
        req_valid = 2'b11;
        #1;
        chk("prio_after_reset", 32'(req_ready), 32'd1);
        req_valid = 2'b10;
        #1;
        chk("req1_alone_ready", 32'(req_ready), 32'd2);
        do_txn(1, RW_READ, 4'h0, 2, 4'h9, 4'h9, 1'b0, 4);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/proto_txn_scheduler.md
Name: proto_txn_scheduler

Overview:
- Round-robin transaction scheduler sharing the single master/slave protocol core between NUM_REQ requesters.
- Accepts one transaction (direction plus data) at a time and pulses start with rw/data held stable to the core.
- Waits for core completion or timeout, then returns a one-cycle response to the granted requester.
- Sits directly above the protocol top, driving its start/rw_in/m_data_in and observing its completion.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DW, 4, data width of protocol data bus
TIMEOUT, 15, max WAIT cycles before transaction aborted with error (>=2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
req_valid  input  NUM_REQ  per-requester transaction request; held until accepted
req_rw  input  NUM_REQ  per-requester direction, 1=read, 0=write
req_wdata  input  NUM_REQ*DW  per-requester write data, requester i at bits [i*DW +: DW]
req_ready  output  NUM_REQ  one-hot accept, high for exactly the accept cycle
rsp_valid  output  NUM_REQ  one-hot response pulse to the originating requester
rsp_rdata  output  DW  read data captured from core, valid with rsp_valid
rsp_err  output  1  timeout flag, valid with rsp_valid
start  output  1  one-cycle start pulse to protocol core
rw_out  output  1  direction to core
wdata_out  output  DW  write data to core
core_done  input  1  one-cycle completion pulse from core
core_rdata  input  DW  data received by core, sampled on core_done
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE; start, rw_out, wdata_out, rsp_valid, rsp_rdata, rsp_err, busy, timer all 0; last_grant=NUM_REQ-1 so requester 0 has first priority. Reset mid-transaction aborts it silently with no response.
- FSM states are IDLE, ISSUE, WAIT and RESP.
- IDLE:
  - req_ready is combinational: one-hot grant of the first valid requester searching from last_grant+1 with wrap-around; zero if no valid.
  - On accept edge: latch grant index, rw and wdata into rw_out/wdata_out; go ISSUE.
- ISSUE: start=1 for exactly one cycle; timer cleared; go WAIT.
- WAIT:
  - start=0; rw_out/wdata_out remain stable.
  - core_done=1: capture core_rdata into rsp_rdata (writes capture too), rsp_err=0; go RESP.
  - Else if timer==TIMEOUT-1: rsp_err=1, rsp_rdata=0; go RESP.
  - Else timer+1.
  - core_done and timeout in the same cycle: done wins.
- RESP: rsp_valid[grant]=1 for one cycle; last_grant<=grant; go IDLE. rsp_rdata/rsp_err hold until the next response.
- Timing: minimum accept-to-response latency is 3 cycles. Accept at edge N, start high N..N+1, earliest done sampled at N+2, rsp_valid at N+3. Next accept is possible the cycle after RESP.
- core_done outside WAIT is ignored.
- Requester deasserting req_valid before accept is legal: it is simply not granted.
- Timer width is clog2(TIMEOUT+1); it never wraps.

Decomposition:
- Package proto_sched_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, RESP}
  - default DW and TIMEOUT constants
  - the RW_READ=1/RW_WRITE=0 constants
- Sub-module rr_arbiter (NUM_REQ): inputs req vector and last_grant; outputs one-hot grant and binary index. Purely combinational; last_grant is stored in the scheduler.

Test Plan:
- Single write: req0 valid, rw=0, wdata=4'hA; core_done 2 cycles after start -> req_ready[0] one cycle, start one cycle with wdata_out=A/rw_out=0, rsp_valid[0] with rsp_err=0.
- Read return: req1 rw=1; core_done with core_rdata=4'h5 -> rsp_valid[1], rsp_rdata=5, rsp_err=0.
- Fairness: req0 and req1 held valid continuously -> grants alternate 0,1,0,1 starting with 0 after reset.
- Timeout: core_done never asserted -> rsp_valid after exactly TIMEOUT WAIT cycles with rsp_err=1, rsp_rdata=0; busy low next cycle.
- Boundary: core_done on the cycle timer==TIMEOUT-1 -> rsp_err=0 with data captured. Stray core_done in IDLE -> no response.
- Reset mid-WAIT: rst low -> all outputs 0 immediately. After release, req1 pending with req0 idle -> req1 granted; priority restarts at 0.
